ro_puf_engine: RTL and testbench

//  Parametrised ring-oscillator PUF measurement engine. Enables NUM_RO ring_oscillator

---
 rtl/ro_puf_engine.sv | 139 +++++++++++++
 tb/tb_ro_puf_engine.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/ro_puf_engine.sv
// ro_puf_engine: ring-oscillator PUF engine; measures each RO over a CLK window and compares adjacent counts.
// The ROs are external (RO_EN/RO_CFG out, RO_OUT in); define RO_PUF_READBACK_EN to add the CNT_SEL/CNT_DATA count readback.
module ro_puf_engine #(
    parameter int NUM_RO   = 9,
    parameter int CNT_W    = 32,
    parameter int WINDOW   = 'hFFFFFF,
    parameter int SETTLE   = 4,
    parameter int RO_CFG_W = 6
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       START,
    input  logic [7:0]                 CHALLENGE,
    input  logic [NUM_RO-1:0]          RO_OUT,
    output logic                       BUSY,
    output logic                       DONE,
    output logic [NUM_RO-2:0]          RESPONSE,
    output logic [NUM_RO-1:0]          RO_EN,
    output logic [RO_CFG_W-1:0]        RO_CFG
`ifdef RO_PUF_READBACK_EN
    ,
    input  logic [$clog2(NUM_RO)-1:0]  CNT_SEL,
    output logic [CNT_W-1:0]           CNT_DATA
`endif
);
    localparam int IW = $clog2(NUM_RO);
    localparam int TW = $clog2(WINDOW > SETTLE ? WINDOW : SETTLE) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_MEASURE, S_SETTLE, S_CAPTURE, S_COMPARE, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [TW-1:0]       tmr_q, tmr_d;
    logic [7:0]          chal_q, chal_d;
    logic [CNT_W-1:0]    cnt_q [NUM_RO];
    logic [CNT_W-1:0]    cnt_d [NUM_RO];
    logic [NUM_RO-2:0]   resp_q, resp_d;
    logic [NUM_RO-1:0]   en_q, en_d;
    logic                clr_q, clr_d;
    logic [CNT_W-1:0]    ro_cnt_q, ro_cnt_d;
    logic                ro_clk;
    logic                ro_rst;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tmr_d   = tmr_q;
        chal_d  = chal_q;
        cnt_d   = cnt_q;
        resp_d  = resp_q;
        case (state_q)
            S_IDLE: if (START) begin
                chal_d  = CHALLENGE;
                idx_d   = '0;
                state_d = S_CLEAR;
            end
            S_CLEAR: begin
                tmr_d   = TW'(WINDOW - 1);
                state_d = S_MEASURE;
            end
            S_MEASURE: if (tmr_q == '0) begin
                tmr_d   = TW'(SETTLE - 1);
                state_d = S_SETTLE;
            end else tmr_d = tmr_q - 1'b1;
            S_SETTLE: if (tmr_q == '0) state_d = S_CAPTURE; else tmr_d = tmr_q - 1'b1;
            S_CAPTURE: begin
                cnt_d[idx_q] = ro_cnt_q;
                if (idx_q == IW'(NUM_RO - 1)) state_d = S_COMPARE;
                else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_CLEAR;
                end
            end
            S_COMPARE: begin
                for (int i = 0; i < NUM_RO - 1; i++) resp_d[i] = cnt_q[i] > cnt_q[i+1];
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
        // Enables and counter clear are registered so the RO side sees glitch-free controls
        clr_d = state_d == S_CLEAR;
        en_d  = '0;
        if (state_d == S_MEASURE) en_d[idx_d] = 1'b1;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            tmr_q   <= '0;
            chal_q  <= '0;
            cnt_q   <= '{default: '0};
            resp_q  <= '0;
            en_q    <= '0;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tmr_q   <= tmr_d;
            chal_q  <= chal_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
            en_q    <= en_d;
            clr_q   <= clr_d;
        end
    end

    // RO-domain edge counter; quasi-static by the time CAPTURE samples it
    assign ro_clk = RO_OUT[idx_q];
    assign ro_rst = RESET | clr_q;

    always_comb ro_cnt_d = ro_cnt_q + 1'b1;

    always_ff @(posedge ro_clk or posedge ro_rst) begin
        if (ro_rst) ro_cnt_q <= '0;
        else        ro_cnt_q <= ro_cnt_d;
    end

    assign BUSY     = state_q != S_IDLE && state_q != S_DONE;
    assign DONE     = state_q == S_DONE;
    assign RESPONSE = resp_q;
    assign RO_EN    = en_q;
    assign RO_CFG   = chal_q[RO_CFG_W-1:0];

`ifdef RO_PUF_READBACK_EN
    logic [CNT_W-1:0] cnt_data_q, cnt_data_d;

    always_comb cnt_data_d = (int'(CNT_SEL) < NUM_RO) ? cnt_q[CNT_SEL] : '0;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) cnt_data_q <= '0;
        else       cnt_data_q <= cnt_data_d;
    end

    assign CNT_DATA = cnt_data_q;
`endif
endmodule

// File: tb/tb_ro_puf_engine.sv
// tb_ro_puf_engine: behavioural ring oscillators driving ro_puf_engine; responses checked against a period-based model.
`timescale 1ns/100ps
module tb_ro_puf_engine;
  localparam int N = 4;
  localparam int W = 100;
  localparam int S = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [7:0] challenge = 8'h00;
  wire [N-1:0] ro_out;
  logic busy, done;
  logic [N-2:0] response;
  logic [N-1:0] ro_en;
  logic [5:0] ro_cfg;
`ifdef RO_PUF_READBACK_EN
  logic [1:0] cnt_sel = 2'd0;
  logic [31:0] cnt_data;
`endif
  int total = 0;
  int bad = 0;
  int multi_en = 0;
  real hp [N];
  logic [7:0] chal;
  ro_puf_engine #(.NUM_RO(N), .CNT_W(32), .WINDOW(W), .SETTLE(S), .RO_CFG_W(6)) dut (
    .CLK(clk), .RESET(rst), .START(start), .CHALLENGE(challenge), .RO_OUT(ro_out),
    .BUSY(busy), .DONE(done), .RESPONSE(response), .RO_EN(ro_en), .RO_CFG(ro_cfg)
`ifdef RO_PUF_READBACK_EN
    , .CNT_SEL(cnt_sel), .CNT_DATA(cnt_data)
`endif
  );
  always #5 clk = ~clk;
  for (genvar g = 0; g < N; g++) begin : osc
    logic o = 1'b0;
    assign ro_out[g] = o;
    initial forever begin
      @(posedge ro_en[g]);
      while (ro_en[g]) begin
        #(hp[g]);
        if (ro_en[g]) o = ~o;
      end
      o = 1'b0;
    end
  end
  always @(negedge clk) if ($countones(ro_en) > 1) multi_en++;
  function automatic void chk(string tag, bit ok, longint obs, longint exp);
    total++;
    if (!ok) begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endfunction
  function automatic logic [N-2:0] model_resp();
    logic [N-2:0] r;
    for (int i = 0; i < N - 1; i++) r[i] = hp[i] < hp[i+1];
    return r;
  endfunction
  task automatic do_run(input bit disturb, output int lat, output int dones,
                        output logic [N-2:0] mid, output logic b1, output logic bd);
    int cyc;
    @(negedge clk); start = 1'b1; challenge = chal;
    @(negedge clk); start = 1'b0; cyc = 1; b1 = busy; mid = 'x; lat = -1;
    while (!done && cyc < 1000) begin
      start = disturb && cyc == 50;
      if (disturb && cyc == 50) challenge = ~challenge;
      @(negedge clk); cyc++;
      if (cyc == 200) mid = response;
    end
    start = 1'b0;
    bd = busy;
    if (done) lat = cyc;
    dones = int'(done);
    for (int i = 0; i < 20; i++) begin @(negedge clk); dones += int'(done); end
  endtask
  initial begin
    int lat, dones, cyc, late_done;
    logic [N-2:0] mid;
    logic b1, bd;
    hp = '{1.0, 1.5, 2.0, 2.5};
    chal = 8'hA5;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy === 1'b0, busy, 0);
    chk("rst_done", done === 1'b0, done, 0);
    chk("rst_resp", response === 3'b000, response, 0);
    chk("rst_en", ro_en === 4'b0000, ro_en, 0);
    do_run(1'b0, lat, dones, mid, b1, bd);
    chk("asc_lat", lat === N * (W + S + 2) + 2, lat, N * (W + S + 2) + 2);
    chk("asc_resp", response === model_resp(), response, model_resp());
    chk("asc_resp_const", response === 3'b111, response, 7);
    chk("asc_busy_first", b1 === 1'b1, b1, 1);
    chk("asc_busy_at_done", bd === 1'b0, bd, 0);
    chk("asc_single_done", dones === 1, dones, 1);
    chk("asc_cfg", ro_cfg === chal[5:0], ro_cfg, chal[5:0]);
`ifdef RO_PUF_READBACK_EN
    for (int i = 0; i < N; i++) begin
      int d;
      cnt_sel = 2'(i);
      @(negedge clk);
      d = int'(cnt_data) - int'($floor(1000.0 / (2.0 * hp[i])));
      chk("readback", d >= -1 && d <= 1, d, 0);
    end
`endif
    repeat (10) @(negedge clk);
    chk("idle_hold", response === 3'b111, response, 7);
    hp = '{2.5, 2.0, 1.5, 1.0};
    do_run(1'b0, lat, dones, mid, b1, bd);
    chk("desc_resp", response === model_resp(), response, model_resp());
    chk("desc_mid_hold", mid === 3'b111, mid, 7);
    chk("desc_lat", lat === N * (W + S + 2) + 2, lat, N * (W + S + 2) + 2);
    hp = '{2.0, 2.0, 2.0, 2.0};
    do_run(1'b0, lat, dones, mid, b1, bd);
    chk("tie_resp", response === 3'b000, response, 0);
    hp = '{1.0, 1.5, 2.0, 2.5};
    chal = 8'h3C;
    do_run(1'b1, lat, dones, mid, b1, bd);
    chk("dist_lat", lat === N * (W + S + 2) + 2, lat, N * (W + S + 2) + 2);
    chk("dist_dones", dones === 1, dones, 1);
    chk("dist_resp", response === 3'b111, response, 7);
    chk("dist_cfg", ro_cfg === chal[5:0], ro_cfg, chal[5:0]);
    @(negedge clk); start = 1'b1; challenge = 8'h11;
    @(negedge clk); start = 1'b0; cyc = 1;
    while (cyc < 150) begin @(negedge clk); cyc++; end
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_en", ro_en === 4'b0000, ro_en, 0);
    chk("mid_rst_busy", busy === 1'b0, busy, 0);
    chk("mid_rst_resp", response === 3'b000, response, 0);
    chk("mid_rst_done", done === 1'b0, done, 0);
    rst = 1'b0;
    late_done = 0;
    for (int i = 0; i < 500; i++) begin @(negedge clk); late_done += int'(done); end
    chk("mid_rst_no_done", late_done === 0, late_done, 0);
    do_run(1'b0, lat, dones, mid, b1, bd);
    chk("post_rst_lat", lat === N * (W + S + 2) + 2, lat, N * (W + S + 2) + 2);
    chk("post_rst_resp", response === 3'b111, response, 7);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < N; i++) hp[i] = 1.0 + 0.5 * real'($urandom_range(0, 4));
      chal = 8'($urandom);
      do_run(1'b0, lat, dones, mid, b1, bd);
      chk("rnd_resp", response === model_resp(), response, model_resp());
      chk("rnd_lat", lat === N * (W + S + 2) + 2, lat, N * (W + S + 2) + 2);
    end
    chk("one_en_max", multi_en === 0, multi_en, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #2ms;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
